// File: rtl/spdif_pkg.sv
// Shared constants, types and the subframe assembly helper for the S/PDIF transmitter.
package spdif_pkg;

    localparam int unsigned SLOTS_PER_SUB    = 32;
    localparam int unsigned FRAMES_PER_BLOCK = 192;
    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned HC_W             = 7;
    localparam int unsigned FRAME_W          = 8;

    // Preamble half-cell patterns, leftmost bit first, for a preceding line level of 0
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    // Slot positions inside a subframe
    localparam int unsigned SLOT_AUX_FIRST = 4;
    localparam int unsigned SLOT_AUDIO_LSB = 12;
    localparam int unsigned SLOT_V         = 28;
    localparam int unsigned SLOT_U         = 29;
    localparam int unsigned SLOT_C         = 30;
    localparam int unsigned SLOT_P         = 31;

    // Channel-status bit indices
    localparam int unsigned CS_COPY_BIT = 2;
    localparam int unsigned CS_FS_FIRST = 24;
    localparam int unsigned CS_FS_LAST  = 27;

    typedef logic [SLOTS_PER_SUB-1:0] subframe_t;

    // Slot-indexed subframe word; preamble slots stay zero, parity is even over slots 4..30
    function automatic subframe_t build_subframe(input logic [SAMPLE_W-1:0] sample,
                                                 input logic cs_bit);
        subframe_t w;
        w = '0;
        w[SLOT_AUDIO_LSB +: SAMPLE_W] = sample;
        w[SLOT_V] = 1'b0;
        w[SLOT_U] = 1'b0;
        w[SLOT_C] = cs_bit;
        w[SLOT_P] = ^w[SLOT_P-1:SLOT_AUX_FIRST];
        return w;
    endfunction

endpackage

// File: rtl/spdif_biphase_encoder.sv
// Biphase-mark line encoder: owns the line level and the preamble polarity.
module spdif_biphase_encoder (
    input  logic clk,
    input  logic clear,
    input  logic tick,
    input  logic is_pre,
    input  logic pre_first,
    input  logic pre_bit,
    input  logic data_bit,
    input  logic phase,
    output logic line
);

    logic pre_inv;
    logic inv;
    logic level_next;

    // Next half-cell level: preamble pattern relative to the entry level, else biphase-mark toggles
    always_comb begin
        inv        = pre_first ? line : pre_inv;
        level_next = line;
        if (is_pre) begin
            level_next = pre_bit ^ inv;
        end else if (!phase) begin
            level_next = ~line;
        end else begin
            level_next = line ^ data_bit;
        end
    end

    // Line register and latched preamble polarity, both advanced only on a half-cell strobe
    always_ff @(posedge clk) begin
        if (clear) begin
            line    <= 1'b0;
            pre_inv <= 1'b0;
        end else if (tick) begin
            line <= level_next;
            if (is_pre && pre_first) begin
                pre_inv <= line;
            end
        end
    end

endmodule

// File: rtl/spdif_transmitter.sv
// IEC 60958 consumer S/PDIF transmitter: frame assembly, channel status and biphase output.
module spdif_transmitter
    import spdif_pkg::*;
#(
    parameter logic       COPY_PERMIT = 1'b1,
    parameter logic [3:0] FS_CODE     = 4'b0100,
    parameter int unsigned HALF_CELLS = 128
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Clk_Ena,
    input  logic                Enable,
    input  logic                Mute,
    input  logic                Audio_Valid,
    input  logic [SAMPLE_W-1:0] Audio_L,
    input  logic [SAMPLE_W-1:0] Audio_R,
    output logic                S_PDIF_Out,
    output logic                Frame_Start,
    output logic                Block_Start,
    output logic                Underrun
);

    logic [HC_W-1:0]     hc;
    logic [FRAME_W-1:0]  frame_idx;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic                new_flag;
    subframe_t           sub_l;
    subframe_t           sub_r;

    logic       tick;
    logic       load;
    logic       cs_bit;
    logic [4:0] slot;
    logic [2:0] pre_idx;
    logic [7:0] pre_word;
    logic       pre_bit;
    logic       data_bit;

    assign tick = Clk_Ena && Enable;
    assign load = tick && (hc == '0);

    // Channel-status bit for the current frame index
    always_comb begin
        cs_bit = 1'b0;
        if (frame_idx == FRAME_W'(CS_COPY_BIT)) begin
            cs_bit = COPY_PERMIT;
        end else if (frame_idx >= FRAME_W'(CS_FS_FIRST) && frame_idx <= FRAME_W'(CS_FS_LAST)) begin
            cs_bit = FS_CODE[2'(3) - frame_idx[1:0]];
        end
    end

    // Half-cell decode into preamble pattern bit and subframe data bit
    always_comb begin
        slot     = hc[5:1];
        pre_idx  = hc[2:0];
        pre_word = PRE_W;
        if (!hc[6]) begin
            pre_word = (frame_idx == '0) ? PRE_B : PRE_M;
        end
        pre_bit  = pre_word[3'(7) - pre_idx];
        data_bit = hc[6] ? sub_r[slot] : sub_l[slot];
    end

    // Half-cell and frame counters; held at zero while disabled
    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            hc        <= '0;
            frame_idx <= '0;
        end else if (Clk_Ena) begin
            if (hc == HC_W'(HALF_CELLS - 1)) begin
                hc        <= '0;
                frame_idx <= (frame_idx == FRAME_W'(FRAMES_PER_BLOCK - 1)) ? '0
                                                                          : frame_idx + FRAME_W'(1);
            end else begin
                hc <= hc + HC_W'(1);
            end
        end
    end

    // Sample handshake: a same-cycle Audio_Valid wins over the load clearing the flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_l   <= '0;
            hold_r   <= '0;
            new_flag <= 1'b0;
        end else if (Audio_Valid) begin
            hold_l   <= Audio_L;
            hold_r   <= Audio_R;
            new_flag <= 1'b1;
        end else if (load) begin
            new_flag <= 1'b0;
        end
    end

    // Subframe words captured from the holding registers at frame load
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sub_l <= '0;
            sub_r <= '0;
        end else if (load) begin
            sub_l <= build_subframe(Mute ? '0 : hold_l, cs_bit);
            sub_r <= build_subframe(Mute ? '0 : hold_r, cs_bit);
        end
    end

    // Frame-level strobes, aligned with half-cell 0 on the line
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Frame_Start <= 1'b0;
            Block_Start <= 1'b0;
            Underrun    <= 1'b0;
        end else begin
            Frame_Start <= load;
            Block_Start <= load && (frame_idx == '0);
            Underrun    <= load && !new_flag;
        end
    end

    spdif_biphase_encoder u_encoder (
        .clk       (Clk),
        .clear     (Reset || !Enable),
        .tick      (tick),
        .is_pre    (hc[5:3] == 3'd0),
        .pre_first (pre_idx == 3'd0),
        .pre_bit   (pre_bit),
        .data_bit  (data_bit),
        .phase     (hc[0]),
        .line      (S_PDIF_Out)
    );

endmodule

// File: tb/tb_spdif_transmitter.sv
// Self-checking bench for spdif_transmitter against a frame-level reference model.
module tb_spdif_transmitter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Clk_Ena;
    logic        Enable;
    logic        Mute;
    logic        Audio_Valid;
    logic [15:0] Audio_L;
    logic [15:0] Audio_R;
    logic        S_PDIF_Out;
    logic        Frame_Start;
    logic        Block_Start;
    logic        Underrun;

    spdif_transmitter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Clk_Ena     (Clk_Ena),
        .Enable      (Enable),
        .Mute        (Mute),
        .Audio_Valid (Audio_Valid),
        .Audio_L     (Audio_L),
        .Audio_R     (Audio_R),
        .S_PDIF_Out  (S_PDIF_Out),
        .Frame_Start (Frame_Start),
        .Block_Start (Block_Start),
        .Underrun    (Underrun)
    );

    always #10 Clk = ~Clk;

    localparam logic [7:0] P_B = 8'hE8;
    localparam logic [7:0] P_M = 8'hE2;
    localparam logic [7:0] P_W = 8'hE4;

    int n_cmp  = 0;
    int n_bad  = 0;
    int bs_cnt = 0;
    int ur_cnt = 0;

    // Reference model state
    int          m_hc    = 0;
    int          m_frame = 0;
    bit          m_level = 1'b0;
    bit          m_flag  = 1'b0;
    bit          m_under = 1'b0;
    logic [15:0] m_hold_l = 16'h0;
    logic [15:0] m_hold_r = 16'h0;
    bit          exp_hc[128];
    bit          obs_hc[128];
    bit          cs_obs[192];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic bit cs_ref(input int f);
        bit fs_slots[4];
        fs_slots = '{1'b0, 1'b1, 1'b0, 1'b0};
        if (f == 2) return 1'b1;
        if (f >= 24 && f <= 27) return fs_slots[f-24];
        return 1'b0;
    endfunction

    // Expected 128 half-cells of one frame, starting from the current line level
    task automatic gen_frame(input logic [15:0] l, input logic [15:0] r, input bit mute, input int f);
        bit          lvl;
        bit          b[32];
        logic [15:0] s;
        logic [7:0]  pat;
        bit          lvl0;
        int          ones;
        int          base;
        lvl = m_level;
        for (int sub = 0; sub < 2; sub++) begin
            base = sub * 64;
            s = mute ? 16'h0 : ((sub == 0) ? l : r);
            for (int i = 0; i < 32; i++) b[i] = 1'b0;
            for (int i = 0; i < 16; i++) b[12+i] = s[i];
            b[30] = cs_ref(f);
            ones = 0;
            for (int i = 4; i <= 30; i++) ones += int'(b[i]);
            b[31] = ((ones % 2) == 1);
            pat = (sub == 1) ? P_W : ((f == 0) ? P_B : P_M);
            lvl0 = lvl;
            for (int h = 0; h < 8; h++) exp_hc[base+h] = pat[7-h] ^ lvl0;
            lvl = exp_hc[base+7];
            for (int sl = 4; sl < 32; sl++) begin
                lvl = ~lvl;
                exp_hc[base+2*sl] = lvl;
                if (b[sl]) lvl = ~lvl;
                exp_hc[base+2*sl+1] = lvl;
            end
        end
    endtask

    function automatic bit dec_slot(input int sub, input int sl);
        return obs_hc[sub*64 + 2*sl] ^ obs_hc[sub*64 + 2*sl + 1];
    endfunction

    function automatic logic [15:0] dec_sample(input int sub);
        logic [15:0] s;
        for (int i = 0; i < 16; i++) s[i] = dec_slot(sub, 12 + i);
        return s;
    endfunction

    function automatic bit dec_parity(input int sub);
        bit p;
        p = 1'b0;
        for (int sl = 4; sl < 32; sl++) p ^= dec_slot(sub, sl);
        return p;
    endfunction

    function automatic logic [7:0] obs_pre(input int sub);
        logic [7:0] p;
        for (int h = 0; h < 8; h++) p[7-h] = obs_hc[sub*64 + h];
        return p;
    endfunction

    // One Clk_Ena strobe plus a random idle gap, with all outputs checked
    task automatic strobe(input bit av, input logic [15:0] l, input logic [15:0] r);
        int gap;
        @(negedge Clk);
        Clk_Ena = 1'b1; Audio_Valid = av; Audio_L = l; Audio_R = r;
        if (Enable && m_hc == 0) begin
            m_under = !m_flag;
            gen_frame(m_hold_l, m_hold_r, Mute, m_frame);
            m_flag = 1'b0;
        end
        if (av) begin m_hold_l = l; m_hold_r = r; m_flag = 1'b1; end
        @(posedge Clk); #1;
        Clk_Ena = 1'b0; Audio_Valid = 1'b0;
        if (Enable) begin
            obs_hc[m_hc] = S_PDIF_Out;
            check("line", S_PDIF_Out, exp_hc[m_hc]);
            check("frame_start", Frame_Start, m_hc == 0);
            check("block_start", Block_Start, m_hc == 0 && m_frame == 0);
            check("underrun", Underrun, m_hc == 0 && m_under);
            m_level = exp_hc[m_hc];
            if (m_hc == 127) begin
                m_hc = 0;
                m_frame = (m_frame == 191) ? 0 : m_frame + 1;
            end else begin
                m_hc++;
            end
        end else begin
            check("dis_line", S_PDIF_Out, 0);
            check("dis_strobes", {Frame_Start, Block_Start, Underrun}, 0);
        end
        if (Block_Start) bs_cnt++;
        if (Underrun) ur_cnt++;
        gap = int'($urandom_range(0, 1));
        for (int g = 0; g < gap; g++) begin
            @(posedge Clk); #1;
            check("line_hold", S_PDIF_Out, Enable ? m_level : 1'b0);
            check("idle_strobes", {Frame_Start, Block_Start, Underrun}, 0);
        end
    endtask

    task automatic give_sample(input logic [15:0] l, input logic [15:0] r);
        @(negedge Clk);
        Audio_Valid = 1'b1; Audio_L = l; Audio_R = r;
        m_hold_l = l; m_hold_r = r; m_flag = 1'b1;
        @(posedge Clk); #1;
        Audio_Valid = 1'b0;
        check("line_hold", S_PDIF_Out, Enable ? m_level : 1'b0);
    endtask

    task automatic set_enable(input bit e);
        @(negedge Clk);
        Enable = e;
        if (!e) begin m_hc = 0; m_frame = 0; m_level = 1'b0; end
        @(posedge Clk); #1;
        check("enable_line", S_PDIF_Out, e ? m_level : 1'b0);
    endtask

    task automatic do_reset(input int cycles, input bit with_ena);
        @(negedge Clk);
        Reset = 1'b1; Clk_Ena = with_ena;
        m_hc = 0; m_frame = 0; m_level = 1'b0; m_flag = 1'b0;
        m_hold_l = 16'h0; m_hold_r = 16'h0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk); #1;
            Clk_Ena = 1'b0;
            check("reset_line", S_PDIF_Out, 0);
            check("reset_strobes", {Frame_Start, Block_Start, Underrun}, 0);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // One full frame of strobes; optional sample at the load cycle and at mid-frame
    task automatic run_frame(input bit av_load, input logic [15:0] l0, input logic [15:0] r0,
                             input bit av_mid,  input logic [15:0] l1, input logic [15:0] r1,
                             output int fidx);
        bit lvl0;
        lvl0 = m_level;
        fidx = m_frame;
        for (int i = 0; i < 128; i++)
            strobe((i == 0) ? av_load : ((i == 64) ? av_mid : 1'b0),
                   (i == 0) ? l0 : l1, (i == 0) ? r0 : r1);
        check("pre_left", obs_pre(0), ((fidx == 0) ? P_B : P_M) ^ {8{lvl0}});
        check("pre_right", obs_pre(1), P_W ^ {8{exp_hc[63]}});
        check("parity_left", dec_parity(0), 0);
        check("parity_right", dec_parity(1), 0);
        check("v_u_bits", {dec_slot(0, 28), dec_slot(0, 29), dec_slot(1, 28), dec_slot(1, 29)}, 0);
        cs_obs[fidx] = dec_slot(0, 30);
    endtask

    initial begin
        int          f;
        int          ur0;
        int          bs0;
        logic [15:0] pl, pr, nl, nr;
        Reset = 1'b1; Clk_Ena = 1'b0; Enable = 1'b0; Mute = 1'b0;
        Audio_Valid = 1'b0; Audio_L = 16'h0; Audio_R = 16'h0;

        do_reset(3, 1'b0);
        set_enable(1'b1);

        // First frame: known extreme samples
        give_sample(16'h8001, 16'h7FFF);
        pl = 16'($urandom); pr = 16'($urandom);
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, pl, pr, f);
        check("first_left", dec_sample(0), 16'h8001);
        check("first_right", dec_sample(1), 16'h7FFF);
        check("first_block_start", bs_cnt, 1);

        // Full block plus two frames with a fresh random sample every frame
        for (int k = 1; k < 194; k++) begin
            nl = 16'($urandom); nr = 16'($urandom);
            run_frame(1'b0, 16'h0, 16'h0, 1'b1, nl, nr, f);
            check("stream_left", dec_sample(0), pl);
            check("stream_right", dec_sample(1), pr);
            pl = nl; pr = nr;
        end
        check("block_start_count", bs_cnt, 2);
        check("no_underrun_stream", ur_cnt, 0);
        for (int i = 0; i < 192; i++)
            check("cs_bit", cs_obs[i], (i == 2 || i == 25));

        // Skip one sample: next load underruns and repeats
        ur0 = ur_cnt;
        run_frame(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, f);
        check("pre_skip_left", dec_sample(0), pl);
        nl = 16'($urandom); nr = 16'($urandom);
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, nl, nr, f);
        check("repeat_left", dec_sample(0), pl);
        check("repeat_right", dec_sample(1), pr);
        check("underrun_once", ur_cnt - ur0, 1);
        pl = nl; pr = nr;

        // Audio_Valid coincident with the load
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, 16'hAAAA, 16'h5555, f);
        ur0 = ur_cnt;
        run_frame(1'b1, 16'h1234, 16'h5678, 1'b0, 16'h0, 16'h0, f);
        check("coincide_old_left", dec_sample(0), 16'hAAAA);
        nl = 16'($urandom); nr = 16'($urandom);
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, nl, nr, f);
        check("coincide_new_left", dec_sample(0), 16'h1234);
        check("coincide_new_right", dec_sample(1), 16'h5678);
        check("coincide_no_underrun", ur_cnt - ur0, 0);

        // Mute zeroes the audio field of a full-scale sample
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFF, 16'hFFFF, f);
        Mute = 1'b1;
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, 16'($urandom), 16'($urandom), f);
        Mute = 1'b0;
        check("mute_left", dec_sample(0), 16'h0);
        check("mute_right", dec_sample(1), 16'h0);

        // Disable mid-frame, load a sample while idle, then restart at frame 0
        for (int i = 0; i < 40; i++) strobe(1'b0, 16'h0, 16'h0);
        set_enable(1'b0);
        for (int i = 0; i < 5; i++) strobe(1'b0, 16'h0, 16'h0);
        nl = 16'($urandom); nr = 16'($urandom);
        give_sample(nl, nr);
        set_enable(1'b1);
        bs0 = bs_cnt;
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, 16'($urandom), 16'($urandom), f);
        check("restart_frame_idx", f, 0);
        check("restart_block_start", bs_cnt - bs0, 1);
        check("restart_left", dec_sample(0), nl);

        // Reset at half-cell 70 of frame 5, coincident with a strobe
        for (int k = 0; k < 8 && m_frame != 5; k++)
            run_frame(1'b0, 16'h0, 16'h0, 1'b1, 16'($urandom), 16'($urandom), f);
        check("reached_frame5", m_frame, 5);
        for (int i = 0; i <= 70; i++) strobe(1'b0, 16'h0, 16'h0);
        do_reset(1, 1'b1);
        give_sample(16'h0F0F, 16'hF0F0);
        bs0 = bs_cnt;
        run_frame(1'b0, 16'h0, 16'h0, 1'b1, 16'($urandom), 16'($urandom), f);
        check("post_reset_frame_idx", f, 0);
        check("post_reset_block_start", bs_cnt - bs0, 1);
        check("post_reset_left", dec_sample(0), 16'h0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spdif_transmitter.md
Name: spdif_transmitter

Overview:
- Consumes the 48 kHz stereo 16-bit samples delivered by the USB audio stage and drives the board's S/PDIF optical/coax output pin, which is currently tied low.
- Builds IEC 60958 consumer frames: preambles, 24-bit audio field, V/U/C/P bits and a 192-frame channel-status block.
- Biphase-mark encodes the frames onto one output bit.
- Runs on the 50 MHz system clock. Half-cell timing comes from an enable strobe generated by the clock-recovery stage.

Parameters:
- COPY_PERMIT, 1, channel-status bit 2 (1 = copying permitted).
- FS_CODE, 4'b0100, channel-status bits 24..27 in slot order 24,25,26,27 (0,1,0,0 = 48 kHz).
- HALF_CELLS, 128, half-cells per frame (2 subframes × 32 slots × 2).

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  synchronous, active-high reset
- Clk_Ena  in  1  one-Clk pulse per half-cell (6.144 MHz average, 128 per 48 kHz frame)
- Enable  in  1  transmit enable (USB audio Active)
- Mute  in  1  force audio field to zero
- Audio_Valid  in  1  one-Clk strobe: Audio_L/Audio_R hold a new sample pair
- Audio_L  in  16  left sample, two's complement
- Audio_R  in  16  right sample, two's complement
- S_PDIF_Out  out  1  biphase-mark line output
- Frame_Start  out  1  one-Clk pulse when half-cell 0 of a frame is emitted
- Block_Start  out  1  one-Clk pulse coincident with Frame_Start for frame 0 (B preamble)
- Underrun  out  1  one-Clk pulse when a frame loads with no new sample since the previous load

Behaviour:
- Reset and output values:
  - Reset is synchronous, active-high. It dominates every other input and may be asserted mid-frame.
  - Outputs after reset: S_PDIF_Out=0, Frame_Start=0, Block_Start=0, Underrun=0.
  - Internal state after reset: half-cell counter=0, frame index=0, holding registers=0, new-sample flag=0, line level=0.
- Holding register:
  - Audio_Valid latches Audio_L/Audio_R into the holding registers and sets the new-sample flag.
- Frame load (the Clk_Ena cycle at half-cell counter 0):
  - Left and right shift words are built from the holding registers. Any Audio_Valid in that same cycle is not used; it is held for the next frame.
  - The new-sample flag is cleared, unless Audio_Valid is also high that cycle, in which case it stays set.
  - Underrun pulses if the flag was 0 at load; the previous sample is then repeated.
  - Frame_Start pulses. Block_Start also pulses when frame index = 0.
- Subframe slot map (slot 0..31):
  - 0-3: preamble.
  - 4-11: zero (aux plus 8 LSB padding).
  - 12-27: sample, LSB at 12, MSB at 27. Zeros if Mute is high at load time.
  - 28: V=0.
  - 29: U=0.
  - 30: C = channel-status bit[frame index], same value in both subframes.
  - 31: P = even parity over slots 4..30.
- Channel status:
  - All 192 bits are 0 except bit 2 = COPY_PERMIT and bits 24..27 = FS_CODE.
- Preambles (8 half-cells, written for a preceding line level of 0; invert all 8 if the preceding level is 1):
  - B = 11101000 on the left subframe of frame 0.
  - M = 11100010 on the left subframe of frames 1..191.
  - W = 11100100 on every right subframe.
- Biphase mark (slots 4..31):
  - Toggle the line level at the start of every slot.
  - Toggle again at mid-slot when the bit is 1.
- Timing:
  - S_PDIF_Out is registered and updates only on Clk_Ena. Half-cell k of a frame appears one Clk after the Clk_Ena that selects k.
  - Between strobes the line holds its level.
- Counters:
  - The half-cell counter wraps 127 -> 0.
  - The frame index wraps 191 -> 0, incrementing at each wrap of the half-cell counter.
- Enable:
  - Enable=0: S_PDIF_Out forced to 0, counters and line level held at reset values, no strobes. The holding register still accepts Audio_Valid.
  - Enable rising: the first Clk_Ena emits half-cell 0 of frame 0 (B preamble).
- Simultaneous events:
  - Audio_Valid and the load in the same cycle: covered under Frame load.
  - Clk_Ena and Reset together: Reset wins.

Decomposition:
- Package spdif_pkg:
  - Preamble constants PRE_B/PRE_M/PRE_W (8 bits each).
  - SLOTS_PER_SUB=32, FRAMES_PER_BLOCK=192.
  - Channel-status bit indices.
  - A subframe-word typedef (32 bits).
- Sub-module spdif_biphase_encoder:
  - Takes a slot bit or preamble half-cell plus the half-cell phase.
  - Owns the line-level register, the preamble inversion and the toggle rules.
- The parent owns the counters, the sample handshake, subframe assembly, parity and the channel-status lookup.

Test Plan:
- Reset, Enable=1, Audio_Valid with L=16'h8001, R=16'h7FFF, then 128 Clk_Ena strobes. Required response:
  - Decoded left slots 12..27 = 0x8001, right = 0x7FFF.
  - Parity even in both subframes.
  - Block_Start at half-cell 0.
  - Preamble B, then W, each with correct polarity.
- Run 192+2 frames with a new sample every frame. Required response:
  - Block_Start only on frames 0 and 192.
  - Decoded C bits: bit 2=1 and bits 24..27 = 0,1,0,0; all other bits 0.
  - M preamble on frames 1..191.
- Skip Audio_Valid for one frame. Required response:
  - Underrun pulses exactly once at that load.
  - That frame repeats the previous sample.
- Audio_Valid in the same Clk as the load with L=16'h1234. Required response:
  - The current frame carries the old sample.
  - The next frame carries 0x1234.
  - No Underrun on the next frame.
- Mute=1 with L=16'hFFFF. Required response: audio slots all 0, parity computed from the zeroed field, V=0.
- Reset asserted at half-cell 70 of frame 5. Required response:
  - S_PDIF_Out=0 on the next Clk.
  - After release, the first Clk_Ena emits the B preamble with frame index 0.
